// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store.
// Latency: gnt same cycle as request in IDLE; rvalid one cycle after mem_rvalid (min 3 cycles gnt-to-gnt, 2 with zero-latency memory).
// Backpressure: one transaction outstanding; requests outside IDLE are held by the requester; mem_* held until mem_gnt.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   if_req/if_addr            fetch request, answered by if_gnt, then if_rvalid/if_rdata/if_err
//   d_req/d_we/d_addr/...     load/store request, answered by d_gnt, then d_rvalid/d_rdata/d_err
//   mem_req/mem_we/...        registered request to memory, held until mem_gnt
//   mem_rvalid/rdata/err      in-order memory response
//   spurious_rsp              sticky flag: response seen while none was expected
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_err,
  output logic                    spurious_rsp
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  state_t        state;
  logic          owner_d;   // 1 = data port owns the outstanding transaction
  logic [SW-1:0] streak;    // data grants since the last fetch grant, saturating

  logic streak_full;
  logic win_d;
  logic win_if;
  logic arb_en;
  logic complete;
  logic spurious_hit;

  // Data wins unless a waiting fetch has already been passed over too often.
  assign streak_full = (streak >= SW'(MAX_DATA_STREAK));
  assign win_d       = d_req && !(if_req && streak_full);
  assign win_if      = if_req && !win_d;
  assign arb_en      = (state == IDLE) && !rst;

  assign if_gnt = arb_en && win_if;
  assign d_gnt  = arb_en && win_d;

  // A response together with mem_gnt covers zero-latency memory.
  assign complete     = ((state == WAIT_GNT) && mem_gnt && mem_rvalid) ||
                        ((state == WAIT_RSP) && mem_rvalid);
  assign spurious_hit = mem_rvalid &&
                        ((state == IDLE) || ((state == WAIT_GNT) && !mem_gnt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      streak       <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      if_rvalid    <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      d_rvalid     <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
      spurious_rsp <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      if (spurious_hit) begin
        spurious_rsp <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (win_d) begin
            owner_d   <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Byte enables only matter for stores; loads read the full word.
            mem_be    <= d_we ? d_be : '1;
            state     <= WAIT_GNT;
            if (!streak_full) begin
              streak <= streak + SW'(1);
            end
          end else if (win_if) begin
            owner_d   <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            state     <= WAIT_GNT;
            streak    <= '0;
          end
        end
        WAIT_GNT: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_rvalid ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (complete) begin
        if (owner_d) begin
          d_rvalid <= 1'b1;
          d_rdata  <= mem_we ? '0 : mem_rdata;
          d_err    <= mem_err;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
          if_err    <= mem_err;
        end
      end
    end
  end

endmodule
